// File: rtl/ball_motion_param.sv
// Parametrised bouncing-ball motion and graphics engine, stepped once per vsync rising edge.
// Optional BALL_MOTION_PAUSE_EN adds a pause input that freezes motion while graphics keep running.

module ball_motion_axis #(
  parameter int W        = 9,
  parameter int SIZE     = 4,
  parameter int MAX      = 256,
  parameter int INIT     = 128,
  parameter int SPEED    = 2,
  parameter bit DIR_INIT = 1'b0
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         step,
  input  logic [W-1:0] beam,
  output logic [W-1:0] pos,
  output logic         hit,
  output logic         in_span
);
  localparam int            W1  = W + 1;
  localparam logic [W:0]    LIM = W1'(MAX - SIZE);
  localparam logic [W:0]    SPD = W1'(SPEED);
  localparam logic [W-1:0]  SZ  = W'(SIZE);
  localparam logic [W-1:0]  P0  = W'(INIT);

  logic         dir;  // 0: toward increasing coordinate, 1: toward zero
  logic [W:0]   ext, fwd;
  logic [W-1:0] offs;

  // Offset wraps on purpose: beam before the ball becomes a huge value and fails the range test.
  always_comb begin
    ext     = {1'b0, pos};
    fwd     = ext + SPD;
    offs    = beam - pos;
    in_span = (offs < SZ);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pos <= P0;
      dir <= DIR_INIT;
      hit <= 1'b0;
    end else begin
      hit <= 1'b0;
      if (step) begin
        if (!dir) begin
          if (fwd >= LIM) begin
            pos <= LIM[W-1:0];
            dir <= 1'b1;
            hit <= 1'b1;
          end else begin
            pos <= fwd[W-1:0];
          end
        end else begin
          if (ext <= SPD) begin
            pos <= '0;
            dir <= 1'b0;
            hit <= 1'b1;
          end else begin
            pos <= pos - SPD[W-1:0];
          end
        end
      end
    end
  end
endmodule

module ball_motion_param #(
  parameter int COORD_W   = 9,
  parameter int BALL_SIZE = 4,
  parameter int H_MAX     = 256,
  parameter int V_MAX     = 240,
  parameter int H_INIT    = 128,
  parameter int V_INIT    = 128,
  parameter int H_SPEED   = 2,
  parameter int V_SPEED   = 2
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               vsync,
`ifdef BALL_MOTION_PAUSE_EN
  input  logic               pause,
`endif
  input  logic               display_on,
  input  logic [COORD_W-1:0] hpos,
  input  logic [COORD_W-1:0] vpos,
  output logic [COORD_W-1:0] ball_x,
  output logic [COORD_W-1:0] ball_y,
  output logic               ball_gfx,
  output logic               ball_hgfx,
  output logic               ball_vgfx,
  output logic               hit_h,
  output logic               hit_v
);
  logic vsync_d, frame_tick, step, h_in, v_in;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) vsync_d <= 1'b0;
    else       vsync_d <= vsync;
  end

  assign frame_tick = vsync & ~vsync_d;

  // vsync_d keeps tracking while paused so un-pausing mid-pulse cannot fake an edge.
`ifdef BALL_MOTION_PAUSE_EN
  assign step = frame_tick & ~pause;
`else
  assign step = frame_tick;
`endif

  ball_motion_axis #(
    .W(COORD_W), .SIZE(BALL_SIZE), .MAX(H_MAX), .INIT(H_INIT), .SPEED(H_SPEED), .DIR_INIT(1'b1)
  ) u_h (
    .clk(clk), .reset(reset), .step(step), .beam(hpos),
    .pos(ball_x), .hit(hit_h), .in_span(h_in)
  );

  ball_motion_axis #(
    .W(COORD_W), .SIZE(BALL_SIZE), .MAX(V_MAX), .INIT(V_INIT), .SPEED(V_SPEED), .DIR_INIT(1'b0)
  ) u_v (
    .clk(clk), .reset(reset), .step(step), .beam(vpos),
    .pos(ball_y), .hit(hit_v), .in_span(v_in)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ball_hgfx <= 1'b0;
      ball_vgfx <= 1'b0;
      ball_gfx  <= 1'b0;
    end else begin
      ball_hgfx <= display_on & h_in;
      ball_vgfx <= display_on & v_in;
      ball_gfx  <= display_on & h_in & v_in;
    end
  end
endmodule

// File: tb/tb_ball_motion_param.sv
// Scoreboard bench for ball_motion_param: a default-parameter instance plus a corner-start instance.
module tb_ball_motion_param;
  logic       clk = 1'b0, reset = 1'b1, vsync = 1'b0, display_on = 1'b0;
  logic [8:0] hpos = '0, vpos = '0;
`ifdef BALL_MOTION_PAUSE_EN
  logic       pause = 1'b0;
`endif
  logic [8:0] ball_x, ball_y, c_x, c_y;
  logic       ball_gfx, ball_hgfx, ball_vgfx, hit_h, hit_v;
  logic       c_g, c_hg, c_vg, c_hh, c_hv;

  always #5 clk = ~clk;

  ball_motion_param #(
    .COORD_W(9), .BALL_SIZE(4), .H_MAX(256), .V_MAX(240),
    .H_INIT(128), .V_INIT(128), .H_SPEED(2), .V_SPEED(2)
  ) u_dut (
    .clk(clk), .reset(reset), .vsync(vsync),
`ifdef BALL_MOTION_PAUSE_EN
    .pause(pause),
`endif
    .display_on(display_on), .hpos(hpos), .vpos(vpos),
    .ball_x(ball_x), .ball_y(ball_y), .ball_gfx(ball_gfx),
    .ball_hgfx(ball_hgfx), .ball_vgfx(ball_vgfx), .hit_h(hit_h), .hit_v(hit_v)
  );

  // Starts one step from the left wall and one step from the bottom wall.
  ball_motion_param #(.H_INIT(2), .V_INIT(234)) u_cor (
    .clk(clk), .reset(reset), .vsync(vsync),
`ifdef BALL_MOTION_PAUSE_EN
    .pause(pause),
`endif
    .display_on(display_on), .hpos(hpos), .vpos(vpos),
    .ball_x(c_x), .ball_y(c_y), .ball_gfx(c_g),
    .ball_hgfx(c_hg), .ball_vgfx(c_vg), .hit_h(c_hh), .hit_v(c_hv)
  );

  typedef struct { int x; int y; bit hh; bit hv; } mot_t;
  typedef struct { bit g; bit hg; bit vg; } gfx_t;
  mot_t q_m[$], q_c[$];
  gfx_t q_g[$];

  int n_chk = 0, n_pass = 0;
  int mx, my, cx, cy;
  bit mdh, mdv, cdh, cdv;

  task automatic chk(input string tag, input int got, input int exp);
    n_chk++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
  endtask

  task automatic model_reset();
    mx = 128; my = 128; mdh = 1'b1; mdv = 1'b0;
    cx = 2;   cy = 234; cdh = 1'b1; cdv = 1'b0;
  endtask

  task automatic step_axis(inout int p, inout bit d, output bit h, input int spd, input int lim);
    h = 1'b0;
    if (!d) begin
      if (p + spd >= lim) begin p = lim; d = 1'b1; h = 1'b1; end
      else p = p + spd;
    end else begin
      if (p <= spd) begin p = 0; d = 1'b0; h = 1'b1; end
      else p = p - spd;
    end
  endtask

  task automatic chk_still(input string tag);
    chk({tag, "_mx"}, ball_x, mx); chk({tag, "_my"}, ball_y, my);
    chk({tag, "_cx"}, c_x, cx);    chk({tag, "_cy"}, c_y, cy);
    chk({tag, "_hits"}, {hit_h, hit_v, c_hh, c_hv}, 0);
  endtask

  // One vsync pulse held for 1+hold cycles; expected step pushed as vsync rises.
  task automatic frame(input int hold);
    mot_t e;
    @(negedge clk);
    vsync = 1'b1;
    step_axis(mx, mdh, e.hh, 2, 252); step_axis(my, mdv, e.hv, 2, 236);
    e.x = mx; e.y = my; q_m.push_back(e);
    step_axis(cx, cdh, e.hh, 2, 252); step_axis(cy, cdv, e.hv, 2, 236);
    e.x = cx; e.y = cy; q_c.push_back(e);
    @(negedge clk);
    e = q_m.pop_front();
    chk("m_x", ball_x, e.x); chk("m_y", ball_y, e.y);
    chk("m_hit_h", hit_h, e.hh); chk("m_hit_v", hit_v, e.hv);
    e = q_c.pop_front();
    chk("c_x", c_x, e.x); chk("c_y", c_y, e.y);
    chk("c_hit_h", c_hh, e.hh); chk("c_hit_v", c_hv, e.hv);
    repeat (hold) @(negedge clk);
    chk_still("vs_high");
    vsync = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  // Drive one beam position per cycle; compare the previous cycle's expectation first.
  task automatic gfx_beat(input int h, input int v, input bit de);
    gfx_t e;
    bit hin, vin;
    @(negedge clk);
    if (q_g.size() > 0) begin
      e = q_g.pop_front();
      chk("hgfx", ball_hgfx, e.hg); chk("vgfx", ball_vgfx, e.vg); chk("gfx", ball_gfx, e.g);
    end
    hpos = 9'(h); vpos = 9'(v); display_on = de;
    hin = (h >= mx) && (h < mx + 4);
    vin = (v >= my) && (v < my + 4);
    e.hg = de && hin; e.vg = de && vin; e.g = de && hin && vin;
    q_g.push_back(e);
  endtask

  task automatic sweep();
    for (int h = mx - 6; h < mx + 8; h++) gfx_beat(h, my + 1, 1'b1);
    for (int v = my - 6; v < my + 8; v++) gfx_beat(mx + 2, v, 1'b1);
    for (int h = mx - 2; h < mx + 6; h++) gfx_beat(h, my + 2, 1'b0);
    gfx_beat(0, 0, 1'b0);
    @(negedge clk);
    q_g.delete();
  endtask

  initial begin
    model_reset();
    repeat (3) @(negedge clk);
    chk("rst_x", ball_x, 128); chk("rst_y", ball_y, 128);
    chk("rst_gfx", {ball_gfx, ball_hgfx, ball_vgfx, c_g, c_hg, c_vg}, 0);
    chk("rst_hit", {hit_h, hit_v, c_hh, c_hv}, 0);
    reset = 1'b0;
    repeat (2) @(negedge clk);

    sweep();
    for (int f = 0; f < 70; f++) frame(1);
    sweep();
    frame(100);

`ifdef BALL_MOTION_PAUSE_EN
    pause = 1'b1;
    for (int f = 0; f < 5; f++) begin
      @(negedge clk); vsync = 1'b1;
      repeat (3) @(negedge clk);
      chk_still("pause");
      vsync = 1'b0;
      repeat (2) @(negedge clk);
    end
    @(negedge clk); vsync = 1'b1;
    repeat (2) @(negedge clk);
    pause = 1'b0;
    repeat (3) @(negedge clk);
    chk_still("unpause_high");
    vsync = 1'b0;
    repeat (2) @(negedge clk);
    frame(1);
`endif

    // Mid-frame asynchronous reset with the beam sitting on the ball.
    @(negedge clk);
    hpos = 9'(mx); vpos = 9'(my); display_on = 1'b1;
    repeat (2) @(negedge clk);
    chk("pre_rst_gfx", ball_gfx, 1);
    #2 reset = 1'b1;
    #1;
    chk("arst_x", ball_x, 128); chk("arst_y", ball_y, 128);
    chk("arst_gfx", {ball_gfx, ball_hgfx, ball_vgfx}, 0);
    chk("arst_cx", c_x, 2); chk("arst_cy", c_y, 234);
    model_reset();
    display_on = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    repeat (3) @(negedge clk);
    chk_still("post_rst");
    frame(1);
    frame(1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
